// File: rtl/display_7seg_mux_pkg.sv
// rtl/display_7seg_mux_pkg.sv - 7-segment patterns and BCD-to-segment decode
// Patterns are stored active-low ({g,f,e,d,c,b,a}, bit 0 = a, 0 = segment lit);
// the top inverts them when the display is active-high.
package display_7seg_mux_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0011000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        case (bcd)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/display_7seg_mux_bcd_digit_counter.sv
// rtl/display_7seg_mux_bcd_digit_counter.sv - one decimal up/down digit with carry/borrow chain
// Ports: clock, reset (async, active high); load/load_digit (load wins);
//        step (a count step is happening this cycle), up_down, cin (carry/borrow in);
//        digit (registered value), cout (combinational carry/borrow out).
module bcd_digit_counter
    import display_7seg_mux_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_digit,
    input  logic       step,
    input  logic       up_down,
    input  logic       cin,
    output logic [3:0] digit,
    output logic       cout
);

    logic [3:0] digit_next;

    always_comb begin
        digit_next = digit;
        cout       = 1'b0;
        if (step) begin
            if (digit > 4'd9) begin
                // A non-decimal code is normalised on any count step, whether or
                // not a carry reaches it: up wraps to 0 and carries, down settles
                // at 9 and swallows any incoming borrow.
                if (up_down) begin
                    digit_next = 4'd0;
                    cout       = 1'b1;
                end else begin
                    digit_next = 4'd9;
                end
            end else if (cin) begin
                if (up_down) begin
                    if (digit == 4'd9) begin
                        digit_next = 4'd0;
                        cout       = 1'b1;
                    end else begin
                        digit_next = digit + 4'd1;
                    end
                end else begin
                    if (digit == 4'd0) begin
                        digit_next = 4'd9;
                        cout       = 1'b1;
                    end else begin
                        digit_next = digit - 4'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            digit <= 4'd0;
        end else if (load) begin
            digit <= load_digit;
        end else begin
            digit <= digit_next;
        end
    end

endmodule

// File: rtl/display_7seg_mux.sv
// rtl/display_7seg_mux.sv - N-digit BCD up/down counter with multiplexed 7-segment display
// Ports: clock, reset (async, active high); enable, up_down, load, load_value (count control);
//        blank_zeros (leading-zero blanking); count (packed BCD), carry (wrap pulse);
//        segmento ({g,f,e,d,c,b,a}), anodo (active-low one-hot digit select).
module display_7seg_mux
    import display_7seg_mux_pkg::*;
#(
    parameter int N_DIGITS    = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  up_down,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] load_value,
    input  logic                  blank_zeros,
    output logic [4*N_DIGITS-1:0] count,
    output logic                  carry,
    output logic [6:0]            segmento,
    output logic [N_DIGITS-1:0]   anodo
);

    localparam int REF_W  = $clog2(REFRESH_DIV);
    localparam int SCAN_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [6:0] SEG_OFF = (ACTIVE_LOW != 0) ? 7'b1111111 : 7'b0000000;

    // Counter chain: digit 0 always sees a carry-in, so a step ripples upward.
    logic                step;
    logic [N_DIGITS:0]   chain;

    assign step     = enable & ~load;
    assign chain[0] = 1'b1;

    for (genvar g = 0; g < N_DIGITS; g++) begin : g_digit
        bcd_digit_counter u_digit (
            .clock      (clock),
            .reset      (reset),
            .load       (load),
            .load_digit (load_value[4*g +: 4]),
            .step       (step),
            .up_down    (up_down),
            .cin        (chain[g]),
            .digit      (count[4*g +: 4]),
            .cout       (chain[g+1])
        );
    end

    // Registered alongside count so the pulse lines up with the wrapped value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            carry <= 1'b0;
        end else begin
            carry <= chain[N_DIGITS];
        end
    end

    // Scan timing.
    logic [REF_W-1:0]  refresh_cnt;
    logic [SCAN_W-1:0] scan_idx;
    logic [SCAN_W-1:0] scan_next;
    logic              refresh_wrap;

    assign refresh_wrap = (refresh_cnt == REF_W'(REFRESH_DIV - 1));

    always_comb begin
        scan_next = scan_idx;
        if (refresh_wrap) begin
            scan_next = (scan_idx == SCAN_W'(N_DIGITS - 1)) ? '0 : scan_idx + 1'b1;
        end
    end

    // Segments are decoded from the index being scanned next, so that after the
    // register stage segmento and anodo always describe the same digit.
    logic [3:0] sel_digit;
    logic       sel_blank;
    logic       upper_zero;
    logic [6:0] seg_pattern;
    logic [6:0] seg_driven;

    always_comb begin
        sel_digit  = 4'd0;
        sel_blank  = 1'b0;
        upper_zero = 1'b1;
        // Walk from the top digit down, so upper_zero means "this digit and all
        // above it are zero" at the point each digit is considered.
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            upper_zero = upper_zero & (count[4*i +: 4] == 4'd0);
            if (scan_next == SCAN_W'(i)) begin
                sel_digit = count[4*i +: 4];
                sel_blank = blank_zeros && (i > 0) && upper_zero;
            end
        end
    end

    assign seg_pattern = sel_blank ? SEG_BLANK : bcd_to_seg(sel_digit);
    assign seg_driven  = (ACTIVE_LOW != 0) ? seg_pattern : ~seg_pattern;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            refresh_cnt <= '0;
            scan_idx    <= '0;
            anodo       <= ~N_DIGITS'(1);
            segmento    <= SEG_OFF;
        end else begin
            refresh_cnt <= refresh_wrap ? '0 : refresh_cnt + 1'b1;
            scan_idx    <= scan_next;
            anodo       <= ~(N_DIGITS'(1) << scan_next);
            segmento    <= seg_driven;
        end
    end

endmodule

// File: doc/display_7seg_mux.md
DISPLAY_7SEG_MUX -- requirements
Module: display_7seg_mux

Interface
REQ-001 Parameter N_DIGITS, default 4, SHALL set the number of BCD digits counted and displayed (range 1..8).
REQ-002 Parameter REFRESH_DIV, default 50000, SHALL set the clock cycles each digit is held during scan (range >= 2).
REQ-003 Parameter ACTIVE_LOW, default 1, SHALL set segment polarity (1: segment on = 0; 0: segment on = 1).
REQ-004 clock  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset  in  1  SHALL be the asynchronous, active-high reset.
REQ-006 enable  in  1  SHALL request one count step per cycle while high.
REQ-007 up_down  in  1  SHALL select direction: 1 = increment, 0 = decrement.
REQ-008 load  in  1  SHALL load load_value into the counter this cycle.
REQ-009 load_value  in  4*N_DIGITS  SHALL be the packed BCD value to load; digit 0 = bits [3:0].
REQ-010 blank_zeros  in  1  SHALL enable leading-zero blanking.
REQ-011 count  out  4*N_DIGITS  SHALL be the registered packed BCD counter value.
REQ-012 carry  out  1  SHALL pulse high for one cycle on wrap (up or down).
REQ-013 segmento  out  7  SHALL drive segments {g,f,e,d,c,b,a}, bit 0 = a, polarity per ACTIVE_LOW.
REQ-014 anodo  out  N_DIGITS  SHALL be the active-low one-hot digit select.

Function
REQ-015 Priority SHALL be load > enable; load with enable high loads, does not count, and does not assert carry.
REQ-016 Increment SHALL be decimal per digit: a digit at 9 becomes 0 and carries into the next digit.
REQ-017 Increment from all-9s SHALL produce all-0s and assert carry in the same cycle count updates.
REQ-018 Decrement from all-0s SHALL produce all-9s and assert carry; a digit at 0 becomes 9 and borrows.
REQ-019 A loaded digit > 9 SHALL display blank; incrementing it SHALL yield 0 with carry; decrementing it SHALL yield 9 without borrow.
REQ-020 count SHALL update one cycle after the sampling edge of load/enable (latency 1).
REQ-021 Refresh counter SHALL count 0..REFRESH_DIV-1 and wrap; on wrap the scan index SHALL advance 0..N_DIGITS-1, then wrap to 0.
REQ-022 anodo SHALL have exactly one bit low, at position scan index; N_DIGITS = 1 holds anodo low permanently.
REQ-023 segmento SHALL be registered and show the decode of the digit at the current scan index, aligned with anodo in the same cycle.
REQ-024 Decode SHALL be 0..9 standard patterns (active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000); other codes blank.
REQ-025 With blank_zeros = 1, digit i > 0 SHALL be blank when digits i..N_DIGITS-1 are all 0; digit 0 SHALL never be blanked.
REQ-026 Counting and scanning SHALL be independent; a count change SHALL appear on segmento no later than the next scan of that digit.

Reset
REQ-027 While reset is high: count = 0, carry = 0, refresh counter = 0, scan index = 0.
REQ-028 While reset is high: anodo = digit 0 selected (bit 0 low, others high); segmento = all segments off.
REQ-029 Reset mid-count or mid-scan SHALL take effect immediately; the first rising edge after release SHALL show "0" on digit 0.

Structure
REQ-030 A shared package SHALL hold the 7-segment pattern constants, the blank constant and the BCD-to-segment decode function.
REQ-031 A sub-module bcd_digit_counter (one 4-bit decimal up/down digit with carry/borrow in and out) SHALL be instantiated N_DIGITS times.

Verification (N_DIGITS=4, REFRESH_DIV=4)
REQ-032 Reset then 12 enable cycles up -> count = 0x0012; digit 0 decode = 0100100.
REQ-033 Load 0x9999, one enable up -> count = 0x0000, carry high exactly one cycle.
REQ-034 Load 0x0000, one enable down -> count = 0x9999, carry pulse; load+enable together with 0x0500 -> count = 0x0500, no carry.
REQ-035 Hold count = 0x0007, blank_zeros = 1, run 16 cycles -> anodo cycles 1110, 1101, 1011, 0111 every 4 cycles; digits 1-3 blank; digit 0 = 1111000.
REQ-036 Load 0x00A3 -> digit 1 blank; one enable up -> count = 0x0104.
REQ-037 Assert reset asynchronously mid-scan at count 0x0456 -> immediately count = 0, anodo = 1110, segmento = 1111111.
